// File: rtl/lcg_seq.sv
// Linear congruential generator sequencer driving an external shift-add multiplier.
// Optional macro LCG_COUNT_EN adds a gen_count output counting generated values.
//
// state | meaning
// IDLE  | waiting for req_next; seed_load allowed
// MUL   | multiplier enabled, waiting for mul_done
// DRAIN | enable dropped, waiting for mul_done to clear
module lcg_seq #(
  parameter int              WIDTH  = 8,
  parameter logic [WIDTH-1:0] MULT_A = 5,
  parameter logic [WIDTH-1:0] INC_C  = 3,
  parameter logic [WIDTH-1:0] SEED   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_next,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_value,
`ifdef LCG_COUNT_EN
  output logic [WIDTH-1:0]   gen_count,
`endif
  output logic [WIDTH-1:0]   rnd_out,
  output logic               rnd_valid,
  output logic               busy,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic               mul_enable,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_result
);

  typedef enum logic [1:0] {IDLE, MUL, DRAIN} fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_val;

  // Upper product bits are discarded: the arithmetic is mod 2^WIDTH.
  logic unused_hi;
  assign unused_hi = ^mul_result[2*WIDTH-1:WIDTH];

  assign next_val         = mul_result[WIDTH-1:0] + INC_C;
  assign mul_multiplicand = state;
  assign mul_multiplier   = MULT_A;
  assign busy             = (fsm != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      state      <= SEED;
      rnd_out    <= SEED;
      rnd_valid  <= 1'b0;
      mul_enable <= 1'b0;
`ifdef LCG_COUNT_EN
      gen_count  <= '0;
`endif
    end else begin
      rnd_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (seed_load) begin
            state <= seed_value;
`ifdef LCG_COUNT_EN
            gen_count <= '0;
`endif
          end else if (req_next) begin
            mul_enable <= 1'b1;
            fsm        <= MUL;
          end
        end
        MUL: begin
          // seed_load takes priority over a product arriving on the same edge
          if (seed_load) begin
            state      <= seed_value;
            mul_enable <= 1'b0;
            fsm        <= DRAIN;
`ifdef LCG_COUNT_EN
            gen_count  <= '0;
`endif
          end else if (mul_done) begin
            state      <= next_val;
            rnd_out    <= next_val;
            rnd_valid  <= 1'b1;
            mul_enable <= 1'b0;
            fsm        <= DRAIN;
`ifdef LCG_COUNT_EN
            gen_count  <= gen_count + 1'b1;
`endif
          end
        end
        DRAIN: begin
          if (seed_load) begin
            state <= seed_value;
`ifdef LCG_COUNT_EN
            gen_count <= '0;
`endif
          end else if (!mul_done) begin
            fsm <= IDLE;
          end
        end
        default: begin
          fsm        <= IDLE;
          mul_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcg_seq.sv
// Directed bench for lcg_seq (WIDTH=8, A=5, C=3, SEED=1) with a 4-cycle multiplier model.
module tb_lcg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_next = 1'b0;
  logic        seed_load = 1'b0;
  logic [7:0]  seed_value = 8'h00;
  logic [7:0]  rnd_out;
  logic        rnd_valid;
  logic        busy;
  logic [7:0]  mul_multiplicand;
  logic [7:0]  mul_multiplier;
  logic        mul_enable;
  logic        mul_done;
  logic [15:0] mul_result;
`ifdef LCG_COUNT_EN
  logic [7:0]  gen_count;
`endif

  int checks = 0;
  int failures = 0;
  int viol = 0;
  logic prev_en = 1'b0;
  logic [2:0] mcnt;

  always #5 clk = ~clk;

  lcg_seq #(.WIDTH(8), .MULT_A(8'd5), .INC_C(8'd3), .SEED(8'd1)) dut (
    .clk(clk),
    .rst(rst),
    .req_next(req_next),
    .seed_load(seed_load),
    .seed_value(seed_value),
`ifdef LCG_COUNT_EN
    .gen_count(gen_count),
`endif
    .rnd_out(rnd_out),
    .rnd_valid(rnd_valid),
    .busy(busy),
    .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier),
    .mul_enable(mul_enable),
    .mul_done(mul_done),
    .mul_result(mul_result)
  );

  // Multiplier model: done 4 cycles after enable rises, held while enabled,
  // cleared one cycle after enable falls.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 3'd0;
      mul_done <= 1'b0;
      mul_result <= 16'h0;
    end else if (mul_enable) begin
      if (mcnt < 3'd4) mcnt <= mcnt + 3'd1;
      if (mcnt == 3'd3) begin
        mul_done <= 1'b1;
        mul_result <= mul_multiplicand * mul_multiplier;
      end
    end else begin
      mcnt <= 3'd0;
      mul_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mul_enable && !prev_en && mul_done) viol++;
    prev_en = mul_enable;
  end

  task automatic do_request(output logic [7:0] val, output int pulses, output int lat,
                            output int busy_gap, output logic [7:0] mcand, output bit timeout);
    int vcyc;
    val = 8'hxx; pulses = 0; lat = -1; busy_gap = -1; vcyc = -1; timeout = 1'b1;
    @(negedge clk) req_next = 1'b1;
    @(negedge clk) req_next = 1'b0;
    mcand = mul_multiplicand;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (rnd_valid) begin
        pulses++;
        val = rnd_out;
        if (vcyc < 0) begin vcyc = i; lat = i; end
      end
      if (!busy) begin
        if (vcyc >= 0) busy_gap = i - vcyc;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rnd_out !== 8'd1 || rnd_valid !== 1'b0 || busy !== 1'b0 || mul_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got out=%0d valid=%b busy=%b en=%b, want out=1 valid=0 busy=0 en=0",
               rnd_out, rnd_valid, busy, mul_enable);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_multiplicand !== 8'd1 || mul_multiplier !== 8'd5) begin
      failures++;
      $display("FAIL reset_operands: got mcand=%0d mplier=%0d, want 1 and 5", mul_multiplicand, mul_multiplier);
    end
`ifdef LCG_COUNT_EN
    checks++;
    if (gen_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d want 0", gen_count);
    end
`endif
  endtask

  task automatic test_basic;
    logic [7:0] v, mc;
    int p, lat, gap;
    bit to;
    logic [7:0] exp_vals [3] = '{8'd43, 8'd218, 8'd69};
    do_request(v, p, lat, gap, mc, to);
    checks++;
    if (to || v !== 8'd8 || p != 1) begin
      failures++;
      $display("FAIL first_value: got %0d pulses=%0d timeout=%0b, want 8 pulses=1", v, p, to);
    end
    checks++;
    if (mc !== 8'd1 || lat != 5 || gap < 0 || gap > 2) begin
      failures++;
      $display("FAIL first_timing: got mcand=%0d lat=%0d busy_gap=%0d, want mcand=1 lat=5 gap<=2", mc, lat, gap);
    end
    for (int i = 0; i < 3; i++) begin
      do_request(v, p, lat, gap, mc, to);
      checks++;
      if (to || v !== exp_vals[i] || p != 1) begin
        failures++;
        $display("FAIL seq_value%0d: got %0d pulses=%0d, want %0d pulses=1", i, v, p, exp_vals[i]);
      end
    end
`ifdef LCG_COUNT_EN
    checks++;
    if (gen_count !== 8'd4) begin
      failures++;
      $display("FAIL count_after4: got %0d want 4", gen_count);
    end
`endif
  endtask

  task automatic test_seed_idle;
    logic [7:0] v, mc;
    int p, lat, gap;
    bit to;
    @(negedge clk) begin seed_load = 1'b1; seed_value = 8'h00; end
    @(negedge clk) seed_load = 1'b0;
    checks++;
    if (mul_multiplicand !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL seed_idle_state: got mcand=%0d busy=%b, want 0 busy=0", mul_multiplicand, busy);
    end
    do_request(v, p, lat, gap, mc, to);
    checks++;
    if (to || v !== 8'd3 || p != 1) begin
      failures++;
      $display("FAIL seed_idle_value: got %0d pulses=%0d, want 3 pulses=1", v, p);
    end
`ifdef LCG_COUNT_EN
    checks++;
    if (gen_count !== 8'd1) begin
      failures++;
      $display("FAIL seed_idle_count: got %0d want 1", gen_count);
    end
`endif
  endtask

  task automatic test_seed_on_done;
    logic [7:0] v, mc;
    int p, lat, gap, stray;
    bit to, seen;
    seen = 1'b0; stray = 0;
    @(negedge clk) req_next = 1'b1;
    @(negedge clk) req_next = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mul_done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL seed_done_wait: mul_done got 0 want 1 within 20 cycles");
    end
    seed_load = 1'b1; seed_value = 8'h10;
    @(negedge clk) seed_load = 1'b0;
    checks++;
    if (rnd_valid !== 1'b0 || mul_enable !== 1'b0 || mul_multiplicand !== 8'h10) begin
      failures++;
      $display("FAIL seed_done_edge: got valid=%b en=%b mcand=%0h, want 0 0 10", rnd_valid, mul_enable, mul_multiplicand);
    end
    for (int i = 0; i < 10 && busy; i++) begin
      @(negedge clk);
      if (rnd_valid) stray++;
    end
    checks++;
    if (stray != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL seed_done_drain: got stray_valid=%0d busy=%b, want 0 0", stray, busy);
    end
    do_request(v, p, lat, gap, mc, to);
    checks++;
    if (to || v !== 8'h53 || p != 1) begin
      failures++;
      $display("FAIL seed_done_next: got %0h pulses=%0d, want 53 pulses=1", v, p);
    end
`ifdef LCG_COUNT_EN
    checks++;
    if (gen_count !== 8'd1) begin
      failures++;
      $display("FAIL seed_done_count: got %0d want 1", gen_count);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0] got [3];
    logic [7:0] exp_vals [3] = '{8'd162, 8'd45, 8'd228};
    int n;
    n = 0;
    viol = 0;
    @(negedge clk) req_next = 1'b1;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge clk);
      if (rnd_valid) begin got[n] = rnd_out; n++; end
    end
    req_next = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    checks++;
    if (n != 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count: got pulses=%0d busy=%b, want 3 busy=0", n, busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= n || got[i] !== exp_vals[i]) begin
        failures++;
        $display("FAIL b2b_value%0d: got %0d want %0d", i, got[i], exp_vals[i]);
      end
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL b2b_enable_over_done: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] v, mc;
    int p, lat, gap;
    bit to;
    @(negedge clk) req_next = 1'b1;
    @(negedge clk) req_next = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mul_enable !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got busy=%b en=%b want 1 1", busy, mul_enable);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mul_enable !== 1'b0 || busy !== 1'b0 || rnd_valid !== 1'b0 || rnd_out !== 8'd1 || mul_multiplicand !== 8'd1) begin
      failures++;
      $display("FAIL rst_mid_outputs: got en=%b busy=%b valid=%b out=%0d mcand=%0d, want 0 0 0 1 1",
               mul_enable, busy, rnd_valid, rnd_out, mul_multiplicand);
    end
    @(negedge clk) rst = 1'b0;
    do_request(v, p, lat, gap, mc, to);
    checks++;
    if (to || v !== 8'd8 || p != 1) begin
      failures++;
      $display("FAIL rst_mid_next: got %0d pulses=%0d, want 8 pulses=1", v, p);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed_idle();
    test_seed_on_done();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
